// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: round-robin push arbiter and flush sequencer for a shared FIFO; FIFO_ARB_STAT_EN adds per-requester push counters
module fifo_push_arbiter #(
  parameter int NumReq    = 4,
  parameter int WordWidth = 64,
  parameter int FlushHold = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NumReq-1:0]                  req_valid_i,
  input  logic [NumReq-1:0][WordWidth-1:0]   req_payload_i,
  output logic [NumReq-1:0]                  req_ready_o,
  output logic                               fifo_push_o,
  output logic [WordWidth-1:0]               fifo_payload_o,
  input  logic                               fifo_full_i,
  output logic                               fifo_flush_o,
  input  logic                               flush_req_i,
  output logic                               flush_done_o,
  output logic [$clog2(NumReq)-1:0]          grant_idx_o,
  output logic                               busy_o,
  output logic [NumReq-1:0][15:0]            stat_cnt_o
);
  localparam int IW = $clog2(NumReq);
  localparam int HW = FlushHold > 0 ? $clog2(FlushHold + 1) : 1;
  typedef enum logic [1:0] {RUN, FLUSH, HOLD} state_t;
  state_t state;
  logic [IW-1:0] rr_ptr;
  logic [HW-1:0] hold_cnt;
  logic found;
  logic elig;
  logic flush_start;
  assign elig = (state == RUN) && !flush_req_i && !fifo_full_i;
  assign flush_start = (state == RUN) && flush_req_i;
  assign fifo_flush_o = state == FLUSH;
  assign busy_o = state != RUN;
  // first valid requester at or after rr_ptr, wrapping
  always_comb begin
    found = 1'b0;
    grant_idx_o = '0;
    for (int k = 0; k < NumReq; k++) begin
      int j;
      j = (int'(rr_ptr) + k) % NumReq;
      if (!found && req_valid_i[j]) begin
        found = 1'b1;
        grant_idx_o = IW'(j);
      end
    end
  end
  assign req_ready_o = (elig && found) ? ({{(NumReq-1){1'b0}}, 1'b1} << grant_idx_o) : '0;
  assign fifo_push_o = |(req_valid_i & req_ready_o);
  assign fifo_payload_o = fifo_push_o ? req_payload_i[grant_idx_o] : '0;
  // pointer moves past the winner after a push; flush restarts it at 0
  always_ff @(posedge clk) begin
    if (rst || flush_start) rr_ptr <= '0;
    else if (fifo_push_o) rr_ptr <= (grant_idx_o == IW'(NumReq - 1)) ? '0 : grant_idx_o + 1'b1;
  end
  // flush sequencer: one FLUSH cycle, FlushHold quiet cycles, then a done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      hold_cnt <= '0;
      flush_done_o <= 1'b0;
    end else begin
      flush_done_o <= 1'b0;
      case (state)
        RUN: if (flush_req_i) state <= FLUSH;
        FLUSH: begin
          hold_cnt <= '0;
          state <= FlushHold > 0 ? HOLD : RUN;
          flush_done_o <= FlushHold == 0;
        end
        HOLD: begin
          hold_cnt <= hold_cnt + 1'b1;
          if (hold_cnt == HW'(FlushHold - 1)) begin
            state <= RUN;
            flush_done_o <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end
`ifdef FIFO_ARB_STAT_EN
  logic [NumReq-1:0][15:0] stat_cnt;
  // saturating per-requester push counters, cleared on flush entry
  always_ff @(posedge clk) begin
    for (int k = 0; k < NumReq; k++)
      if (rst || flush_start) stat_cnt[k] <= '0;
      else if (req_valid_i[k] && req_ready_o[k] && stat_cnt[k] != 16'hFFFF) stat_cnt[k] <= stat_cnt[k] + 16'd1;
  end
  assign stat_cnt_o = stat_cnt;
`else
  assign stat_cnt_o = '0;
`endif
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb_fifo_push_arbiter: scoreboard bench for the round-robin push arbiter and flush sequencer
module tb_fifo_push_arbiter;
  localparam int N = 4;
  localparam int W = 64;
  localparam int IW = 2;
  localparam logic [N-1:0] ONE = 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req_valid_i = '0;
  logic [N-1:0][W-1:0] req_payload_i = '0;
  logic [N-1:0] req_ready_o;
  logic fifo_push_o;
  logic [W-1:0] fifo_payload_o;
  logic fifo_full_i = 1'b0;
  logic fifo_flush_o;
  logic flush_req_i = 1'b0;
  logic flush_done_o;
  logic [IW-1:0] grant_idx_o;
  logic busy_o;
  logic [N-1:0][15:0] stat_cnt_o;

  fifo_push_arbiter #(.NumReq(N), .WordWidth(W), .FlushHold(2)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .req_payload_i(req_payload_i),
    .req_ready_o(req_ready_o), .fifo_push_o(fifo_push_o), .fifo_payload_o(fifo_payload_o),
    .fifo_full_i(fifo_full_i), .fifo_flush_o(fifo_flush_o), .flush_req_i(flush_req_i),
    .flush_done_o(flush_done_o), .grant_idx_o(grant_idx_o), .busy_o(busy_o), .stat_cnt_o(stat_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {int idx; logic [W-1:0] pl;} exp_t;
  exp_t q[$];
  exp_t e;
  int n_tests = 0;
  int n_fail = 0;
  int m_ptr = 0;
  bit exp_push;
  logic [N-1:0] exp_rdy;

  task automatic drive(input logic [N-1:0] v, input logic full, input logic fr, input bit elig);
    exp_t x;
    int j;
    req_valid_i = v;
    fifo_full_i = full;
    flush_req_i = fr;
    for (int i = 0; i < N; i++) req_payload_i[i] = {$urandom, $urandom};
    exp_push = 1'b0;
    exp_rdy = '0;
    if (elig)
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (!exp_push && v[j]) begin
          exp_push = 1'b1;
          x.idx = j;
          x.pl = req_payload_i[j];
          q.push_back(x);
          exp_rdy = ONE << j;
          m_ptr = (j + 1) % N;
        end
      end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive('0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (req_ready_o !== '0 || fifo_push_o !== 1'b0 || fifo_flush_o !== 1'b0 || busy_o !== 1'b0 || flush_done_o !== 1'b0 || stat_cnt_o !== '0) begin
      n_fail++;
      $display("FAIL reset: ready=%b push=%b flush=%b busy=%b done=%b stat=%h, want all 0", req_ready_o, fifo_push_o, fifo_flush_o, busy_o, flush_done_o, stat_cnt_o);
    end
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
  endtask

  task automatic test_round_robin();
    for (int c = 0; c < 8; c++) begin
      drive(4'hF, 1'b0, 1'b0, 1'b1);
      if (exp_push) e = q.pop_front(); else e = '{idx: 0, pl: '0};
      n_tests++;
      if (fifo_push_o !== exp_push || req_ready_o !== exp_rdy || fifo_payload_o !== e.pl || grant_idx_o !== IW'(c % N)) begin
        n_fail++;
        $display("FAIL round_robin c%0d: push=%b ready=%b idx=%0d payload=%h, want push=%b ready=%b idx=%0d payload=%h", c, fifo_push_o, req_ready_o, grant_idx_o, fifo_payload_o, exp_push, exp_rdy, c % N, e.pl);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_skip_idle();
    logic [N-1:0] vv [5] = '{4'b0001, 4'b0010, 4'b1010, 4'b1010, 4'b1010};
    int gg [5] = '{0, 1, 3, 1, 3};
    for (int c = 0; c < 5; c++) begin
      drive(vv[c], 1'b0, 1'b0, 1'b1);
      if (exp_push) e = q.pop_front(); else e = '{idx: 0, pl: '0};
      n_tests++;
      if (fifo_push_o !== 1'b1 || req_ready_o !== exp_rdy || fifo_payload_o !== e.pl || grant_idx_o !== IW'(gg[c])) begin
        n_fail++;
        $display("FAIL skip_idle c%0d: push=%b ready=%b idx=%0d payload=%h, want push=1 ready=%b idx=%0d payload=%h", c, fifo_push_o, req_ready_o, grant_idx_o, fifo_payload_o, exp_rdy, gg[c], e.pl);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    bit full;
    int gg;
    for (int c = 0; c < 5; c++) begin
      full = c >= 1 && c <= 3;
      gg = c == 0 ? 0 : 1;
      drive(4'hF, full, 1'b0, !full);
      if (exp_push) e = q.pop_front(); else e = '{idx: 0, pl: '0};
      n_tests++;
      if (fifo_push_o !== !full || req_ready_o !== exp_rdy || fifo_payload_o !== e.pl || (!full && grant_idx_o !== IW'(gg))) begin
        n_fail++;
        $display("FAIL backpressure c%0d: push=%b ready=%b idx=%0d payload=%h, want push=%b ready=%b idx=%0d payload=%h", c, fifo_push_o, req_ready_o, grant_idx_o, fifo_payload_o, !full, exp_rdy, gg, e.pl);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_flush_seq(input int len, input logic [15:0] fr, input logic [15:0] fl, input logic [15:0] bz, input logic [15:0] dn, input logic [15:0] gr, input string name);
    m_ptr = 0;
    for (int k = 0; k < len; k++) begin
      drive(4'hF, 1'b0, fr[k], gr[k]);
      if (exp_push) e = q.pop_front(); else e = '{idx: 0, pl: '0};
      n_tests++;
      if (fifo_flush_o !== fl[k] || busy_o !== bz[k] || flush_done_o !== dn[k] || fifo_push_o !== gr[k] || req_ready_o !== (gr[k] ? ONE : '0) || fifo_payload_o !== e.pl || (gr[k] && grant_idx_o !== '0)) begin
        n_fail++;
        $display("FAIL %s t+%0d: flush=%b busy=%b done=%b push=%b ready=%b idx=%0d, want flush=%b busy=%b done=%b push=%b ready=%b idx=0", name, k, fifo_flush_o, busy_o, flush_done_o, fifo_push_o, req_ready_o, grant_idx_o, fl[k], bz[k], dn[k], gr[k], gr[k] ? ONE : '0);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_flush();
    drive(4'hF, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    drive(4'hF, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    drive(4'hF, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (busy_o !== 1'b1 || fifo_push_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_flush hold: busy=%b push=%b, want busy=1 push=0", busy_o, fifo_push_o);
    end
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    for (int k = 0; k < 3; k++) begin
      drive(k == 0 ? 4'hF : 4'h0, 1'b0, 1'b0, 1'b1);
      if (exp_push) e = q.pop_front(); else e = '{idx: 0, pl: '0};
      n_tests++;
      if (busy_o !== 1'b0 || fifo_flush_o !== 1'b0 || flush_done_o !== 1'b0 || stat_cnt_o !== '0 || fifo_push_o !== exp_push || req_ready_o !== exp_rdy || fifo_payload_o !== e.pl) begin
        n_fail++;
        $display("FAIL mid_flush after c%0d: busy=%b flush=%b done=%b stat=%h push=%b ready=%b, want busy=0 flush=0 done=0 stat=0 push=%b ready=%b", k, busy_o, fifo_flush_o, flush_done_o, stat_cnt_o, fifo_push_o, req_ready_o, exp_push, exp_rdy);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stats();
    logic [N-1:0][15:0] want;
    rst = 1'b1;
    drive('0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    for (int c = 0; c < 5; c++) begin
      drive(4'b0100, 1'b0, 1'b0, 1'b1);
      if (exp_push) e = q.pop_front(); else e = '{idx: 0, pl: '0};
      n_tests++;
      if (fifo_push_o !== 1'b1 || grant_idx_o !== 2'd2 || fifo_payload_o !== e.pl) begin
        n_fail++;
        $display("FAIL stats push c%0d: push=%b idx=%0d payload=%h, want push=1 idx=2 payload=%h", c, fifo_push_o, grant_idx_o, fifo_payload_o, e.pl);
      end
      @(negedge clk);
    end
    want = '0;
`ifdef FIFO_ARB_STAT_EN
    want[2] = 16'd5;
`endif
    drive('0, 1'b0, 1'b1, 1'b0);
    n_tests++;
    if (stat_cnt_o !== want) begin
      n_fail++;
      $display("FAIL stats count: stat=%h, want %h", stat_cnt_o, want);
    end
    @(negedge clk);
    drive('0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (stat_cnt_o !== '0 || fifo_flush_o !== 1'b1) begin
      n_fail++;
      $display("FAIL stats flush clear: stat=%h flush=%b, want stat=0 flush=1", stat_cnt_o, fifo_flush_o);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_round_robin();
    test_skip_idle();
    test_backpressure();
    test_flush_seq(5, 16'b00001, 16'b00010, 16'b01110, 16'b10000, 16'b10000, "flush");
    test_flush_seq(9, 16'b000010001, 16'b000100010, 16'b011101110, 16'b100010000, 16'b100000000, "back_to_back");
    test_reset_mid_flush();
    test_stats();
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard drain: %0d entries left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
